// File: rtl/ldm_stm_seq_if.sv
// ldm_stm_seq_if
//   Bundles every non-clock signal of the LDM/STM block-transfer sequencer.
//   Signal names keep the sequencer-side direction suffixes (_i into the
//   sequencer, _o out of it).
//   Groups:
//     command   : start_i, load_i, up_i, pre_i, wb_i, rn_i, base_i, reglist_i
//     rf read   : ra_o -> rdata_i (combinational return)
//     rf write  : we_o, wa_o, wd_o (registered)
//     pc load   : pc_we_o, pc_o (registered)
//     memory    : mreq_o, mwe_o, maddr_o, mwdata_o, mrdata_i, mack_i
//     status    : busy_o, done_o
//   master = the sequencer, slave = the surrounding pipeline/memory/rf.
interface ldm_stm_seq_if;
  logic        start_i;
  logic        load_i;
  logic        up_i;
  logic        pre_i;
  logic        wb_i;
  logic [3:0]  rn_i;
  logic [31:0] base_i;
  logic [15:0] reglist_i;

  logic [3:0]  ra_o;
  logic [31:0] rdata_i;

  logic        we_o;
  logic [3:0]  wa_o;
  logic [31:0] wd_o;
  logic        pc_we_o;
  logic [31:0] pc_o;

  logic        mreq_o;
  logic        mwe_o;
  logic [31:0] maddr_o;
  logic [31:0] mwdata_o;
  logic [31:0] mrdata_i;
  logic        mack_i;

  logic        busy_o;
  logic        done_o;

  modport master (
    input  start_i, load_i, up_i, pre_i, wb_i, rn_i, base_i, reglist_i,
    output ra_o,
    input  rdata_i,
    output we_o, wa_o, wd_o, pc_we_o, pc_o,
    output mreq_o, mwe_o, maddr_o, mwdata_o,
    input  mrdata_i, mack_i,
    output busy_o, done_o
  );

  modport slave (
    output start_i, load_i, up_i, pre_i, wb_i, rn_i, base_i, reglist_i,
    input  ra_o,
    output rdata_i,
    input  we_o, wa_o, wd_o, pc_we_o, pc_o,
    input  mreq_o, mwe_o, maddr_o, mwdata_o,
    output mrdata_i, mack_i,
    input  busy_o, done_o
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq
//   Block-transfer sequencer for LDM/STM. Walks a 16-bit register list in
//   ascending order, one register per memory handshake, driving the rf write
//   port (loads), the rf third read port (stores) and the data-memory port.
//   Optionally finishes with a base-register writeback. Loads of r15 go out
//   on the PC port since the rf drops writes to r15.
//   Ports:
//     clk  - clock, all state changes on posedge
//     rst  - synchronous active-high reset; aborts any transfer in flight
//     bus  - ldm_stm_seq_if.master (command, rf, pc, memory, status)
//   Flow: IDLE -> XFER -> [WB] -> DONE -> IDLE
module ldm_stm_seq (
  input  logic          clk,
  input  logic          rst,
  ldm_stm_seq_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_e;

  // Command fields captured at start and held for the whole transfer.
  typedef struct packed {
    logic        load;
    logic        wb;
    logic [3:0]  rn;
    logic [15:0] list;    // original list, needed for the Rn-in-list test
    logic [31:0] wb_val;
  } cmd_t;

  state_e      state_q, state_d;
  cmd_t        cmd_q;
  logic [15:0] list_q;    // registers still to transfer
  logic [31:0] addr_q;    // current word address

  logic        we_q, pc_we_q;
  logic [3:0]  wa_q;
  logic [31:0] wd_q, pc_q;

  // ---------------------------------------------------------------------
  // Start-time address arithmetic (all mod 2^32)
  // ---------------------------------------------------------------------
  logic [4:0]  n_start;
  logic [31:0] four_n;
  logic [31:0] lowest_addr;
  logic [31:0] wb_val;

  always_comb begin
    n_start = '0;
    for (int k = 0; k < 16; k++) n_start += {4'b0, bus.reglist_i[k]};
  end

  assign four_n = {25'b0, n_start, 2'b00};

  always_comb begin
    lowest_addr = bus.base_i;
    unique case ({bus.up_i, bus.pre_i})
      2'b10: lowest_addr = bus.base_i;                    // IA
      2'b11: lowest_addr = bus.base_i + 32'd4;            // IB
      2'b00: lowest_addr = bus.base_i - four_n + 32'd4;   // DA
      2'b01: lowest_addr = bus.base_i - four_n;           // DB
      default: lowest_addr = bus.base_i;
    endcase
  end

  assign wb_val = bus.up_i ? (bus.base_i + four_n) : (bus.base_i - four_n);

  // ---------------------------------------------------------------------
  // Current register: lowest bit still set in the remaining list
  // ---------------------------------------------------------------------
  logic [3:0]  cur_reg;
  logic [15:0] cur_onehot;
  logic        last_beat;
  logic        beat_ack;
  logic        do_wb;

  always_comb begin
    cur_reg = '0;
    for (int k = 15; k >= 0; k--) begin
      if (list_q[k]) cur_reg = 4'(k);
    end
  end

  assign cur_onehot = 16'b1 << cur_reg;
  assign last_beat  = (list_q & ~cur_onehot) == 16'b0;
  assign beat_ack   = (state_q == S_XFER) && bus.mack_i;

  // A load that overwrites Rn from memory wins over the writeback; a
  // writeback to r15 would be dropped by the rf anyway, so skip it.
  assign do_wb = cmd_q.wb && (cmd_q.rn != 4'd15) &&
                 !(cmd_q.load && cmd_q.list[cmd_q.rn]);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = (n_start == 5'd0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        if (beat_ack && last_beat) state_d = do_wb ? S_WB : S_DONE;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      list_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      pc_we_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      // rf and PC strobes are single-cycle pulses
      we_q    <= 1'b0;
      pc_we_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            cmd_q.load   <= bus.load_i;
            cmd_q.wb     <= bus.wb_i;
            cmd_q.rn     <= bus.rn_i;
            cmd_q.list   <= bus.reglist_i;
            cmd_q.wb_val <= wb_val;
            list_q       <= bus.reglist_i;
            addr_q       <= lowest_addr;
          end
        end
        S_XFER: begin
          if (bus.mack_i) begin
            list_q <= list_q & ~cur_onehot;
            addr_q <= addr_q + 32'd4;
            if (cmd_q.load) begin
              if (cur_reg == 4'd15) begin
                pc_we_q <= 1'b1;
                pc_q    <= bus.mrdata_i;
              end else begin
                we_q <= 1'b1;
                wa_q <= cur_reg;
                wd_q <= bus.mrdata_i;
              end
            end
          end
        end
        S_WB: begin
          we_q <= 1'b1;
          wa_q <= cmd_q.rn;
          wd_q <= cmd_q.wb_val;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. Memory-side outputs derive only from registered state, so
  // they hold steady across a stalled handshake.
  // ---------------------------------------------------------------------
  assign bus.mreq_o   = (state_q == S_XFER);
  assign bus.mwe_o    = (state_q == S_XFER) && !cmd_q.load;
  assign bus.maddr_o  = addr_q;
  assign bus.ra_o     = cur_reg;
  assign bus.mwdata_o = bus.rdata_i;

  assign bus.we_o     = we_q;
  assign bus.wa_o     = wa_q;
  assign bus.wd_o     = wd_q;
  assign bus.pc_we_o  = pc_we_q;
  assign bus.pc_o     = pc_q;

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_ldm_stm_seq.sv
module tb_ldm_stm_seq;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ldm_stm_seq_if bus ();

  ldm_stm_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Fake register file and memory: fixed functions of address.
  function automatic logic [31:0] rf_fn(input logic [3:0] r);
    return 32'hCAFE_0000 | {16'h0, 4'h0, r, 4'h0, r};
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [31:0] x;
    x = {a[15:0], ~a[31:16]};
    return x ^ 32'h1357_9BDF;
  endfunction

  assign bus.rdata_i  = rf_fn(bus.ra_o);
  assign bus.mrdata_i = mem_fn(bus.maddr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One transfer: build the expected trace from the architectural rules,
  // run the DUT with randomized ack delays in [mind,maxd], compare.
  task automatic run_txn(input bit load, input bit up, input bit pre, input bit wb,
                         input logic [3:0] rn, input logic [31:0] base,
                         input logic [15:0] list, input int mind, input int maxd);
    int          regs[$];
    logic [31:0] eaddr[$];
    logic [3:0]  ewa[$];
    logic [31:0] ewd[$];
    logic [31:0] epc[$];
    bit          ewb;
    int          n;
    logic [31:0] oaddr[$];
    logic        omwe[$];
    logic [3:0]  ora[$];
    logic [31:0] osd[$];
    logic [3:0]  owa[$];
    logic [31:0] owd[$];
    logic        odone[$];
    logic [31:0] opc[$];
    int          cyc, dones, done_cyc, stab_err, wait_left;
    bit          fin, in_beat;
    logic [31:0] b_addr;
    logic        b_mwe;
    logic [3:0]  b_ra;

    for (int k = 0; k < 16; k++) if (list[k]) regs.push_back(k);
    n = regs.size();
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      if (up) a = base + 32'(4 * (i + int'(pre)));
      else    a = base - 32'(4 * n) + 32'(4 * (i + int'(!pre)));
      eaddr.push_back(a);
      if (load) begin
        if (regs[i] == 15) epc.push_back(mem_fn(a));
        else begin ewa.push_back(4'(regs[i])); ewd.push_back(mem_fn(a)); end
      end
    end
    ewb = (n > 0) && wb && (rn != 4'd15) && !(load && list[rn]);
    if (ewb) begin
      ewa.push_back(rn);
      ewd.push_back(up ? base + 32'(4 * n) : base - 32'(4 * n));
    end

    @(negedge clk);
    bus.load_i = load; bus.up_i = up; bus.pre_i = pre; bus.wb_i = wb;
    bus.rn_i = rn; bus.base_i = base; bus.reglist_i = list;
    bus.start_i = 1'b1; bus.mack_i = 1'b0;

    cyc = 0; dones = 0; done_cyc = -1; stab_err = 0; wait_left = 0;
    fin = 1'b0; in_beat = 1'b0; b_addr = '0; b_mwe = 1'b0; b_ra = '0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.we_o) begin owa.push_back(bus.wa_o); owd.push_back(bus.wd_o); odone.push_back(bus.done_o); end
      if (bus.pc_we_o) opc.push_back(bus.pc_o);
      if (bus.done_o) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      fin = !bus.busy_o;
      if (bus.mreq_o) begin
        if (!in_beat) begin
          in_beat = 1'b1; b_addr = bus.maddr_o; b_mwe = bus.mwe_o; b_ra = bus.ra_o;
          wait_left = $urandom_range(mind, maxd);
        end else if (bus.maddr_o !== b_addr || bus.mwe_o !== b_mwe || bus.ra_o !== b_ra) begin
          stab_err++;
        end
        if (wait_left == 0) begin
          bus.mack_i = 1'b1; in_beat = 1'b0;
          oaddr.push_back(bus.maddr_o); omwe.push_back(bus.mwe_o);
          ora.push_back(bus.ra_o); osd.push_back(bus.mwdata_o);
        end else begin
          bus.mack_i = 1'b0; wait_left--;
        end
      end else begin
        bus.mack_i = 1'($urandom_range(0, 1));   // must be ignored
      end
      bus.start_i = fin ? 1'b0 : 1'($urandom_range(0, 1));  // ignored while busy
    end
    bus.mack_i = 1'b0; bus.start_i = 1'b0;

    check("finish", 32'(fin), 32'd1);
    check("nbeats", oaddr.size(), n);
    for (int i = 0; i < n && i < oaddr.size(); i++) begin
      check("maddr", oaddr[i], eaddr[i]);
      check("mwe", 32'(omwe[i]), 32'(!load));
      check("ra", 32'(ora[i]), 32'(regs[i]));
      if (!load) check("mwdata", osd[i], rf_fn(4'(regs[i])));
    end
    check("nwrites", owa.size(), ewa.size());
    for (int i = 0; i < ewa.size() && i < owa.size(); i++) begin
      check("wa", 32'(owa[i]), 32'(ewa[i]));
      check("wd", owd[i], ewd[i]);
    end
    if (ewb && odone.size() > 0) check("wb_in_done", 32'(odone[odone.size()-1]), 32'd1);
    check("npc", opc.size(), epc.size());
    if (epc.size() > 0 && opc.size() > 0) check("pc", opc[0], epc[0]);
    check("dones", dones, 1);
    check("stable", stab_err, 0);
    if (n == 0) check("done_lat", done_cyc, 1);
  endtask

  initial begin
    logic [15:0] rl;
    logic [31:0] rb;

    rst = 1'b1;
    bus.start_i = 1'b0; bus.load_i = 1'b0; bus.up_i = 1'b0; bus.pre_i = 1'b0;
    bus.wb_i = 1'b0; bus.rn_i = '0; bus.base_i = '0; bus.reglist_i = '0;
    bus.mack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mreq", 32'(bus.mreq_o), 0);
    check("rst_we", 32'(bus.we_o), 0);
    check("rst_pcwe", 32'(bus.pc_we_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_maddr", bus.maddr_o, 0);
    check("rst_wd", bus.wd_o, 0);
    rst = 1'b0;

    // LDMIA r0!,{r1,r3}
    run_txn(1, 1, 0, 1, 4'd0, 32'h100, 16'h000A, 0, 0);
    // STMDB r13!,{r4,r14}
    run_txn(0, 0, 1, 1, 4'd13, 32'h1000, 16'h4010, 0, 0);
    // LDMIB r2!,{r2,r15}
    run_txn(1, 1, 1, 1, 4'd2, 32'h200, 16'h8004, 0, 0);
    // three-cycle ack delay on every beat
    run_txn(1, 0, 0, 1, 4'd5, 32'h3000, 16'h00F0, 3, 3);
    // empty list with writeback requested
    run_txn(1, 1, 0, 1, 4'd4, 32'h500, 16'h0000, 0, 0);
    // full list, address wraps around zero
    run_txn(0, 1, 0, 1, 4'd3, 32'hFFFF_FFF0, 16'hFFFF, 0, 1);
    // STM with Rn in list still writes back
    run_txn(0, 1, 1, 1, 4'd6, 32'h800, 16'h00C1, 0, 2);

    // Reset during a 4-register LDM, after the first ack
    @(negedge clk);
    bus.load_i = 1'b1; bus.up_i = 1'b1; bus.pre_i = 1'b0; bus.wb_i = 1'b1;
    bus.rn_i = 4'd0; bus.base_i = 32'h40; bus.reglist_i = 16'h001E;
    bus.start_i = 1'b1; bus.mack_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("mid_mreq", 32'(bus.mreq_o), 1);
    bus.mack_i = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.mack_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.mack_i = 1'b0;
    check("abort_mreq", 32'(bus.mreq_o), 0);
    check("abort_we", 32'(bus.we_o), 0);
    check("abort_busy", 32'(bus.busy_o), 0);
    check("abort_pcwe", 32'(bus.pc_we_o), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(bus.done_o), 0);
    end
    run_txn(1, 1, 0, 1, 4'd7, 32'h9000, 16'h0036, 0, 1);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      rl = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rb = $urandom & 32'hFFFF_FFFC;
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), rb, rl, 0, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
